// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: one data-valid strobe per byte,
// each frame closed by the transmitter's done handshake and an optional idle gap.
module uart_tx_feeder #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int GAP_CLKS = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [7:0]        wr_data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic              busy_o,
  output logic              tx_dv_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_active_i,
  input  logic              tx_done_i
);

  localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

  typedef enum logic [2:0] {
    SYNC, IDLE, LAUNCH, WAIT_DONE, WAIT_CLR, GAP
  } state_t;

  state_t            r_state;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;
  logic              r_dv;
  logic [7:0]        r_byte;
  logic [GW-1:0]     r_gap;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = (r_state == IDLE) && !w_empty;
  // A pop frees a slot this cycle, so a push into a full FIFO still lands.
  assign w_push  = wr_en_i && (!w_full || w_pop);

  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign count_o    = r_count;
  assign overflow_o = r_ovf;
  assign busy_o     = (r_state != IDLE) || !w_empty;
  assign tx_dv_o    = r_dv;
  assign tx_byte_o  = r_byte;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_ovf <= wr_en_i && w_full && !w_pop;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= SYNC;
      r_dv    <= 1'b0;
      r_byte  <= 8'h00;
      r_gap   <= '0;
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        SYNC: begin
          if (!tx_active_i && !tx_done_i) r_state <= IDLE;
        end
        IDLE: begin
          if (!w_empty) begin
            r_byte  <= r_mem[r_rd_ptr];
            r_dv    <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done_i) r_state <= WAIT_CLR;
        end
        WAIT_CLR: begin
          // Done low again means the transmitter is back in idle.
          if (!tx_done_i) begin
            if (GAP_CLKS == 0) begin
              r_state <= IDLE;
            end else begin
              r_gap   <= GW'(GAP_CLKS);
              r_state <= GAP;
            end
          end
        end
        GAP: begin
          if (r_gap <= GW'(1)) r_state <= IDLE;
          else                 r_gap   <= r_gap - 1'b1;
        end
        default: begin
          r_state <= SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: two instances (DEPTH=4 no gap, DEPTH=16 gap=10)
// each driving a behavioural UART transmitter with 4 clocks per bit.
module tb_uart_tx_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ser(int t, logic [7:0] sh);
    if (t < 0 || t >= 36) return 1'b1;
    if (t < 4) return 1'b0;
    return sh[(t - 4) / 4];
  endfunction

  // ---------------- instance A: DEPTH=4, GAP_CLKS=0
  logic       a_wr = 1'b0;
  logic [7:0] a_wd = 8'h00;
  logic       a_full, a_empty, a_ovf, a_busy, a_dv;
  logic [2:0] a_cnt;
  logic [7:0] a_byte;
  logic       a_act, a_done, a_ser;
  int         a_t = -1;
  logic [7:0] a_sh = 8'h00;
  logic       a_hold = 1'b0;

  uart_tx_feeder #(.DEPTH(4), .ADDR_W(2), .GAP_CLKS(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(a_wr), .wr_data_i(a_wd),
    .full_o(a_full), .empty_o(a_empty), .count_o(a_cnt),
    .overflow_o(a_ovf), .busy_o(a_busy), .tx_dv_o(a_dv),
    .tx_byte_o(a_byte), .tx_active_i(a_act), .tx_done_i(a_done)
  );

  always @(posedge clk) begin
    if (a_t < 0) begin
      if (a_dv) begin
        a_t  <= 0;
        a_sh <= a_byte;
      end
    end else if (a_t == 41) begin
      a_t <= -1;
    end else if (!(a_t == 39 && a_hold)) begin
      a_t <= a_t + 1;
    end
  end

  assign a_act  = (a_t >= 0) && (a_t < 40);
  assign a_done = (a_t == 40) || (a_t == 41);
  assign a_ser  = ser(a_t, a_sh);

  logic       a_dv_q = 1'b0;
  logic       a_done_q = 1'b0;
  logic [9:0] a_bits = '0;
  logic [9:0] a_frame = '0;
  bit         a_skip = 1'b0;
  int         a_dvq[$];
  int         a_fallq[$];
  logic [7:0] a_sb[$];

  always @(negedge clk) begin
    if (a_dv) begin
      chk("a_dv_b2b", a_dv_q, 1'b0);
      chk("a_dv_txidle", a_t < 0, 1'b1);
      if (a_sb.size() == 0) chk("a_sb_empty", 1, 0);
      else chk("a_byte", a_byte, a_sb.pop_front());
      a_dvq.push_back(cyc);
      a_skip = 1'b0;
    end
    if (a_t >= 0 && !a_skip) chk("a_byte_hold", a_byte, a_sh);
    if (a_done_q && !a_done) a_fallq.push_back(cyc);
    if (a_t >= 0 && a_t < 40 && a_t % 4 == 2) a_bits[a_t / 4] = a_ser;
    if (a_t == 39) a_frame = a_bits;
    a_dv_q   = a_dv;
    a_done_q = a_done;
  end

  // ---------------- instance B: DEPTH=16, GAP_CLKS=10
  logic       b_wr = 1'b0;
  logic [7:0] b_wd = 8'h00;
  logic       b_full, b_empty, b_ovf, b_busy, b_dv;
  logic [4:0] b_cnt;
  logic [7:0] b_byte;
  logic       b_act, b_done;
  int         b_t = -1;

  uart_tx_feeder #(.DEPTH(16), .ADDR_W(4), .GAP_CLKS(10)) u_gap (
    .clk_i(clk), .rst_i(rst), .wr_en_i(b_wr), .wr_data_i(b_wd),
    .full_o(b_full), .empty_o(b_empty), .count_o(b_cnt),
    .overflow_o(b_ovf), .busy_o(b_busy), .tx_dv_o(b_dv),
    .tx_byte_o(b_byte), .tx_active_i(b_act), .tx_done_i(b_done)
  );

  always @(posedge clk) begin
    if (b_t < 0) begin
      if (b_dv) b_t <= 0;
    end else if (b_t == 41) begin
      b_t <= -1;
    end else begin
      b_t <= b_t + 1;
    end
  end

  assign b_act  = (b_t >= 0) && (b_t < 40);
  assign b_done = (b_t == 40) || (b_t == 41);

  logic       b_dv_q = 1'b0;
  logic       b_done_q = 1'b0;
  int         b_dvq[$];
  int         b_fallq[$];
  logic [7:0] b_sb[$];

  always @(negedge clk) begin
    if (b_dv) begin
      chk("b_dv_b2b", b_dv_q, 1'b0);
      chk("b_dv_txidle", b_t < 0, 1'b1);
      if (b_sb.size() == 0) chk("b_sb_empty", 1, 0);
      else chk("b_byte", b_byte, b_sb.pop_front());
      b_dvq.push_back(cyc);
    end
    if (b_done_q && !b_done) b_fallq.push_back(cyc);
    b_dv_q   = b_dv;
    b_done_q = b_done;
  end

  // ---------------- stimulus helpers
  task automatic a_put(logic [7:0] d, bit keep);
    @(posedge clk); #1;
    a_wr = 1'b1;
    a_wd = d;
    if (keep) a_sb.push_back(d);
  endtask

  task automatic a_stop();
    @(posedge clk); #1;
    a_wr = 1'b0;
  endtask

  task automatic b_put(logic [7:0] d);
    @(posedge clk); #1;
    b_wr = 1'b1;
    b_wd = d;
    b_sb.push_back(d);
  endtask

  task automatic a_wait_idle(string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!a_busy && a_t < 0 && a_sb.size() == 0) return;
    end
    chk(tag, 0, 1);
  endtask

  task automatic b_wait_idle(string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!b_busy && b_t < 0 && b_sb.size() == 0) return;
    end
    chk(tag, 0, 1);
  endtask

  task automatic a_wait_fall(string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (a_done) seen = 1'b1;
      else if (seen) return;
    end
    chk(tag, 0, 1);
  endtask

  task automatic a_wait_t(int t, string tag);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (a_t == t) return;
    end
    chk(tag, 0, 1);
  endtask

  int p;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_full", a_full, 1'b0);
    chk("rst_empty", a_empty, 1'b1);
    chk("rst_count", a_cnt, 3'd0);
    chk("rst_ovf", a_ovf, 1'b0);
    chk("rst_busy", a_busy, 1'b1);
    chk("rst_dv", a_dv, 1'b0);
    chk("rst_byte", a_byte, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("sync_exit_busy", a_busy, 1'b0);

    // single byte, latency, serial frame, busy release
    a_dvq.delete();
    a_put(8'hA5, 1'b1);
    p = cyc;
    a_stop();
    a_wait_fall("t1_fall_to");
    chk("t1_busy_fall_cyc", a_busy, 1'b1);
    @(negedge clk);
    chk("t1_busy_after", a_busy, 1'b0);
    a_wait_idle("t1_idle_to");
    chk("t1_ndv", a_dvq.size(), 1);
    if (a_dvq.size() > 0) chk("t1_lat", a_dvq[0] - p, 2);
    chk("t1_serial", a_frame, 10'b1101001010);

    // three back-to-back bytes
    a_dvq.delete();
    a_fallq.delete();
    a_put(8'h01, 1'b1);
    a_put(8'h02, 1'b1);
    a_put(8'h03, 1'b1);
    a_stop();
    a_wait_idle("t2_idle_to");
    chk("t2_ndv", a_dvq.size(), 3);
    if (a_dvq.size() == 3 && a_fallq.size() >= 2) begin
      chk("t2_gap1", a_dvq[1] - a_fallq[0], 2);
      chk("t2_gap2", a_dvq[2] - a_fallq[1], 2);
    end

    // overflow while stalled in WAIT_DONE
    a_dvq.delete();
    a_hold = 1'b1;
    a_put(8'h5A, 1'b1);
    a_stop();
    a_wait_t(39, "t3_stall_to");
    for (int i = 0; i < 6; i++) begin
      a_put(8'hB0 + 8'(i), i < 4);
      if (i == 2) begin
        chk("t3_cnt2", a_cnt, 3'd2);
        chk("t3_notfull", a_full, 1'b0);
      end
      if (i == 4) begin
        chk("t3_full", a_full, 1'b1);
        chk("t3_cnt4", a_cnt, 3'd4);
        chk("t3_noovf4", a_ovf, 1'b0);
      end
      if (i == 5) begin
        chk("t3_ovf5", a_ovf, 1'b1);
        chk("t3_cnt5", a_cnt, 3'd4);
      end
    end
    a_stop();
    chk("t3_ovf6", a_ovf, 1'b1);
    @(posedge clk); #1;
    chk("t3_ovf_clr", a_ovf, 1'b0);

    // full FIFO: push lands in the same cycle as the IDLE pop
    a_hold = 1'b0;
    a_wait_fall("t4_fall_to");
    @(posedge clk); #1;
    a_wr = 1'b1;
    a_wd = 8'h77;
    a_sb.push_back(8'h77);
    @(posedge clk); #1;
    a_wr = 1'b0;
    chk("t4_cnt", a_cnt, 3'd4);
    chk("t4_ovf", a_ovf, 1'b0);
    chk("t4_full", a_full, 1'b1);
    a_wait_idle("t4_idle_to");
    chk("t4_ndv", a_dvq.size(), 6);

    // programmable gap on instance B
    b_dvq.delete();
    b_fallq.delete();
    b_put(8'h11);
    b_put(8'h22);
    @(posedge clk); #1;
    b_wr = 1'b0;
    chk("t5_cnt", b_cnt, 5'd1);
    b_wait_idle("t5_idle_to");
    chk("t5_ndv", b_dvq.size(), 2);
    if (b_dvq.size() == 2 && b_fallq.size() >= 1)
      chk("t5_gap", b_dvq[1] - b_fallq[0], 12);

    // reset mid-frame with bytes queued
    a_dvq.delete();
    a_put(8'hC1, 1'b1);
    a_put(8'hC2, 1'b1);
    a_put(8'hC3, 1'b1);
    a_stop();
    a_wait_t(10, "t6_mid_to");
    rst = 1'b1;
    a_skip = 1'b1;
    #1;
    chk("t6_cnt", a_cnt, 3'd0);
    chk("t6_empty", a_empty, 1'b1);
    chk("t6_dv", a_dv, 1'b0);
    chk("t6_byte", a_byte, 8'h00);
    chk("t6_busy", a_busy, 1'b1);
    a_sb.delete();
    a_dvq.delete();
    @(negedge clk);
    rst = 1'b0;
    a_put(8'h3C, 1'b1);
    a_stop();
    a_wait_idle("t6_idle_to");
    chk("t6_ndv", a_dvq.size(), 1);
    chk("t6_serial", a_frame, {1'b1, 8'h3C, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
